main_mem_responder: RTL and testbench

MAIN_MEM_RESPONDER -- requirements
Module: main_mem_responder

---
 rtl/main_mem_responder.sv | 109 ++++++++++
 tb/tb_main_mem_responder.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/main_mem_responder.sv
// main_mem_responder: word-addressed main memory that serves block fills and writebacks
// as fixed-length bursts after a configurable access latency.
module main_mem_responder #(
    parameter int MEM_SIZE   = 256,
    parameter int BLOCK_SIZE = 4,
    parameter int LATENCY    = 2
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  mem_req,
    input  logic                                  mem_rw,
    input  logic [$clog2(MEM_SIZE/BLOCK_SIZE)-1:0] mem_block_addr,
    input  logic [31:0]                           mem_wdata,
    input  logic                                  mem_wvalid,
    output logic                                  mem_wready,
    output logic [31:0]                           mem_rdata,
    output logic                                  mem_rvalid,
    output logic                                  mem_ack,
    output logic                                  mem_busy,
    output logic [2:0]                            state_o
);
    localparam int BW  = $clog2(BLOCK_SIZE);
    localparam int BAW = $clog2(MEM_SIZE/BLOCK_SIZE);
    localparam int LW  = LATENCY > 1 ? $clog2(LATENCY) : 1;
    localparam logic [LW-1:0] LAT_INIT = LW'(LATENCY > 0 ? LATENCY - 1 : 0);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT  = 3'd1,
        READ  = 3'd2,
        WRITE = 3'd3,
        ACK   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [BW-1:0]    beat_q, beat_d;
    logic [LW-1:0]    lat_q, lat_d;
    logic [BAW-1:0]   addr_q, addr_d;
    logic             rw_q, rw_d;
    logic [BAW+BW-1:0] word_addr;
    logic [31:0]      mem_q [MEM_SIZE];

    assign word_addr = {addr_q, beat_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            beat_q  <= '0;
            lat_q   <= '0;
            addr_q  <= '0;
            rw_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            lat_q   <= lat_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
        end
    end

    // Reset restores the identity image, so an aborted writeback leaves no trace.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MEM_SIZE; i++) mem_q[i] <= 32'(i);
        end else if (state_q == WRITE && mem_wvalid) begin
            mem_q[word_addr] <= mem_wdata;
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        lat_d   = lat_q;
        addr_d  = addr_q;
        rw_d    = rw_q;
        unique case (state_q)
            IDLE: if (mem_req) begin
                addr_d  = mem_block_addr;
                rw_d    = mem_rw;
                beat_d  = '0;
                lat_d   = LAT_INIT;
                state_d = LATENCY > 0 ? WAIT : (mem_rw ? WRITE : READ);
            end
            WAIT: begin
                state_d = lat_q == '0 ? (rw_q ? WRITE : READ) : WAIT;
                lat_d   = lat_q == '0 ? lat_q : lat_q - 1'b1;
            end
            READ: begin
                beat_d  = beat_q + 1'b1;
                state_d = &beat_q ? ACK : READ;
            end
            WRITE: if (mem_wvalid) begin
                beat_d  = beat_q + 1'b1;
                state_d = &beat_q ? ACK : WRITE;
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_rvalid = state_q == READ;
        mem_rdata  = mem_rvalid ? mem_q[word_addr] : '0;
        mem_wready = state_q == WRITE;
        mem_ack    = state_q == ACK;
        mem_busy   = state_q != IDLE;
        state_o    = state_q;
    end
endmodule

// File: tb/tb_main_mem_responder.sv
// tb_main_mem_responder: randomized bursts on a LATENCY=2 and a LATENCY=0 instance,
// checked against an array model of memory and the cycle timing of each transfer.
module tb_main_mem_responder;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset, mem_req, mem_rw, mem_wvalid, mem_wready, mem_rvalid, mem_ack, mem_busy;
    logic [5:0]  mem_block_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [2:0]  state_o;
    logic        z_req, z_rw, z_wvalid, z_wready, z_rvalid, z_ack, z_busy;
    logic [5:0]  z_block_addr;
    logic [31:0] z_wdata, z_rdata;
    logic [2:0]  z_state;

    int checks = 0;
    int errors = 0;
    logic [31:0] ref_mem [256];

    always #5 clk = ~clk;

    main_mem_responder dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_rw(mem_rw),
        .mem_block_addr(mem_block_addr), .mem_wdata(mem_wdata), .mem_wvalid(mem_wvalid),
        .mem_wready(mem_wready), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .mem_ack(mem_ack), .mem_busy(mem_busy), .state_o(state_o)
    );

    main_mem_responder #(.LATENCY(0)) dut0 (
        .clk(clk), .reset(reset), .mem_req(z_req), .mem_rw(z_rw),
        .mem_block_addr(z_block_addr), .mem_wdata(z_wdata), .mem_wvalid(z_wvalid),
        .mem_wready(z_wready), .mem_rdata(z_rdata), .mem_rvalid(z_rvalid),
        .mem_ack(z_ack), .mem_busy(z_busy), .state_o(z_state)
    );

    task automatic init_ref();
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'(i);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mem_req = 1'b0; mem_rw = 1'b0; mem_block_addr = '0; mem_wdata = '0; mem_wvalid = 1'b0;
        z_req = 1'b0; z_rw = 1'b0; z_block_addr = '0; z_wdata = '0; z_wvalid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        init_ref();
    endtask

    // Entered and left at a falling edge; the request is presented for one cycle.
    task automatic do_read(input int blk, input bit noise);
        int  beats = 0;
        bit  done = 1'b0;
        checks++;
        if (state_o !== 3'd0) begin errors++; $display("FAIL rd_start_idle got %0d exp 0", state_o); end
        mem_req = 1'b1; mem_rw = 1'b0; mem_block_addr = 6'(blk);
        for (int c = 1; c <= 40 && !done; c++) begin
            @(negedge clk);
            mem_req = 1'b0;
            if (noise && (state_o == 3'd1 || state_o == 3'd2)) begin
                mem_req = 1'($urandom); mem_rw = 1'($urandom); mem_block_addr = 6'($urandom);
            end
            checks++;
            if (mem_rvalid) begin
                if (mem_rdata !== ref_mem[blk*4+beats] || c != LAT + 1 + beats) begin
                    errors++;
                    $display("FAIL rd_beat blk %0d beat %0d got %0h at cycle %0d exp %0h at cycle %0d",
                             blk, beats, mem_rdata, c, ref_mem[blk*4+beats], LAT + 1 + beats);
                end
                beats++;
            end else if (mem_rdata !== 32'd0) begin
                errors++; $display("FAIL rd_idle_data got %0h exp 0", mem_rdata);
            end
            if (mem_ack) begin
                checks++;
                if (c != LAT + 5 || beats != 4) begin
                    errors++; $display("FAIL rd_ack got cycle %0d beats %0d exp cycle %0d beats 4", c, beats, LAT + 5);
                end
                done = 1'b1;
            end
        end
        mem_req = 1'b0;
        if (!done) begin checks++; errors++; $display("FAIL rd_timeout blk %0d got no ack exp ack", blk); end
        @(negedge clk);
        checks++;
        if (mem_busy !== 1'b0 || state_o !== 3'd0 || mem_ack !== 1'b0) begin
            errors++; $display("FAIL rd_after busy %0b state %0d ack %0b exp 0 0 0", mem_busy, state_o, mem_ack);
        end
    endtask

    // Holds mem_wvalid low for gap_len WRITE cycles once beat gap_beat has been written.
    task automatic do_write(input int blk, input logic [127:0] wd, input int gap_beat, input int gap_len);
        int k = 0;
        int gaps = 0;
        bit done = 1'b0;
        checks++;
        if (state_o !== 3'd0) begin errors++; $display("FAIL wr_start_idle got %0d exp 0", state_o); end
        mem_req = 1'b1; mem_rw = 1'b1; mem_block_addr = 6'(blk); mem_wvalid = 1'b0;
        for (int c = 1; c <= 40 && !done; c++) begin
            @(negedge clk);
            mem_req = 1'b0;
            checks++;
            if (mem_wready !== (c >= LAT + 1 && c < LAT + 5 + gap_len)) begin
                errors++; $display("FAIL wr_ready cycle %0d got %0b", c, mem_wready);
            end
            if (mem_wready) begin
                mem_wvalid = 1'b0;
                if (k == gap_beat + 1 && gaps < gap_len) gaps++;
                else if (k < 4) begin
                    mem_wvalid = 1'b1;
                    mem_wdata = wd[32*k +: 32];
                    ref_mem[blk*4+k] = mem_wdata;
                    k++;
                end
            end else begin
                mem_wvalid = 1'($urandom);
                mem_wdata = $urandom;
            end
            if (mem_ack) begin
                checks++;
                if (c != LAT + 5 + gap_len || k != 4) begin
                    errors++; $display("FAIL wr_ack got cycle %0d beats %0d exp cycle %0d beats 4", c, k, LAT + 5 + gap_len);
                end
                done = 1'b1;
            end
        end
        if (!done) begin checks++; errors++; $display("FAIL wr_timeout blk %0d got no ack exp ack", blk); end
        @(negedge clk);
        mem_wvalid = 1'b0;
        checks++;
        if (mem_busy !== 1'b0 || state_o !== 3'd0) begin
            errors++; $display("FAIL wr_after busy %0b state %0d exp 0 0", mem_busy, state_o);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (state_o !== 3'd0 || mem_busy !== 1'b0 || mem_ack !== 1'b0 || mem_rvalid !== 1'b0 ||
            mem_wready !== 1'b0 || mem_rdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs state %0d busy %0b ack %0b rvalid %0b wready %0b rdata %0h exp all 0",
                     state_o, mem_busy, mem_ack, mem_rvalid, mem_wready, mem_rdata);
        end
    endtask

    task automatic test_read();
        do_read(5, 1'b0);
        for (int i = 0; i < 3; i++) do_read(int'($urandom_range(0, 63)), 1'b0);
    endtask

    task automatic test_write();
        do_write(63, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, -5, 0);
        do_read(63, 1'b0);
        do_read(62, 1'b0);
        for (int i = 0; i < 3; i++) begin
            int b = int'($urandom_range(0, 63));
            do_write(b, {$urandom, $urandom, $urandom, $urandom}, -5, 0);
            do_read(b, 1'b0);
        end
    endtask

    task automatic test_wvalid_gap();
        do_write(10, {$urandom, $urandom, $urandom, $urandom}, 1, 2);
        do_read(10, 1'b0);
        do_read(11, 1'b0);
        for (int i = 0; i < 3; i++) begin
            int b = int'($urandom_range(0, 63));
            do_write(b, {$urandom, $urandom, $urandom, $urandom},
                     int'($urandom_range(0, 2)), int'($urandom_range(1, 3)));
            do_read(b, 1'b0);
        end
    endtask

    task automatic test_ignore();
        for (int i = 0; i < 4; i++) do_read(int'($urandom_range(0, 63)), 1'b1);
        @(negedge clk);
        checks++;
        if (state_o !== 3'd0 || mem_busy !== 1'b0) begin
            errors++; $display("FAIL ignore_no_extra state %0d busy %0b exp 0 0", state_o, mem_busy);
        end
    endtask

    task automatic test_reset_midburst();
        int beats = 0;
        bit hit = 1'b0;
        do_write(0, {$urandom, $urandom, $urandom, $urandom}, -5, 0);
        mem_req = 1'b1; mem_rw = 1'b0; mem_block_addr = 6'd0;
        for (int c = 1; c <= 40 && !hit; c++) begin
            @(negedge clk);
            mem_req = 1'b0;
            if (mem_rvalid) beats++;
            if (beats == 3) begin reset = 1'b1; hit = 1'b1; end
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL midburst_reach got beats %0d exp 3", beats); end
        @(negedge clk);
        reset = 1'b0;
        init_ref();
        checks++;
        if (state_o !== 3'd0 || mem_busy !== 1'b0 || mem_ack !== 1'b0 || mem_rvalid !== 1'b0 ||
            mem_wready !== 1'b0 || mem_rdata !== 32'd0) begin
            errors++;
            $display("FAIL midburst_abort state %0d busy %0b ack %0b rvalid %0b rdata %0h exp all 0",
                     state_o, mem_busy, mem_ack, mem_rvalid, mem_rdata);
        end
        @(negedge clk);
        checks++;
        if (mem_ack !== 1'b0 || state_o !== 3'd0) begin
            errors++; $display("FAIL midburst_no_ack ack %0b state %0d exp 0 0", mem_ack, state_o);
        end
        do_read(0, 1'b0);
    endtask

    task automatic test_latency0();
        for (int t = 0; t < 3; t++) begin
            int  blk = t == 0 ? 1 : int'($urandom_range(0, 63));
            int  beats = 0;
            bit  done = 1'b0;
            z_req = 1'b1; z_block_addr = 6'(blk);
            for (int c = 1; c <= 20 && !done; c++) begin
                @(negedge clk);
                z_req = 1'b0;
                if (z_rvalid) begin
                    checks++;
                    if (z_rdata !== 32'(blk*4+beats) || c != 1 + beats) begin
                        errors++;
                        $display("FAIL lat0_beat blk %0d beat %0d got %0h at cycle %0d exp %0h at cycle %0d",
                                 blk, beats, z_rdata, c, blk*4+beats, 1 + beats);
                    end
                    beats++;
                end
                if (z_ack) begin
                    checks++;
                    if (c != 5 || beats != 4) begin
                        errors++; $display("FAIL lat0_ack got cycle %0d beats %0d exp cycle 5 beats 4", c, beats);
                    end
                    done = 1'b1;
                end
            end
            if (!done) begin checks++; errors++; $display("FAIL lat0_timeout got no ack exp ack"); end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_wvalid_gap();
        test_ignore();
        test_reset_midburst();
        test_latency0();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
